// File: rtl/lr_sc_reservation.sv
// LR/SC reservation station for one hart.
// Holds one reservation granule. It answers the SC outcome in the first cycle
// of an SC window and freezes that outcome until the window closes. The
// reservation is dropped on any SC, a conflicting store, a trap or a timeout.
module lr_sc_reservation #(
  parameter int XLEN           = 32,
  parameter int GRANULE_LSB    = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            lr_valid,
  input  logic [XLEN-1:0] lr_addr,
  input  logic            sc_valid,
  input  logic [XLEN-1:0] sc_addr,
  output logic            sc_success,
  input  logic            snoop_we,
  input  logic [XLEN-1:0] snoop_addr,
  input  logic            invalidate_all,
  output logic            rsv_valid,
  output logic [XLEN-1:0] rsv_addr
);

  // Clears the offset bits inside a granule.
  localparam logic [XLEN-1:0] GRAN_MASK = {XLEN{1'b1}} << GRANULE_LSB;
  // Counter value on which a live reservation expires at the next edge.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  logic [CNT_W-1:0] cnt;
  logic             sc_active;
  logic             sc_result_q;
  logic             sc_match;
  logic             snoop_hit;
  logic             timeout_hit;
  logic             sc_end;
  logic             clear_req;

  // rsv_addr keeps its offset bits at zero, so masking the probe address is enough.
  function automatic logic granule_hit(input logic [XLEN-1:0] probe,
                                       input logic [XLEN-1:0] held);
    return (probe & GRAN_MASK) == held;
  endfunction

  assign sc_match    = rsv_valid && granule_hit(sc_addr, rsv_addr);
  assign snoop_hit   = snoop_we && rsv_valid && granule_hit(snoop_addr, rsv_addr);
  assign timeout_hit = TIMEOUT_EN && rsv_valid && (cnt == CNT_LAST);
  assign sc_end      = !sc_valid && sc_active;
  assign clear_req   = snoop_hit || timeout_hit || sc_end;

  // SC outcome: live match in the first window cycle, frozen value afterwards.
  always_comb begin
    sc_success = 1'b0;
    if (sc_valid) begin
      sc_success = sc_active ? sc_result_q : sc_match;
    end
  end

  // Track the SC window and latch the first-cycle outcome.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc_active   <= 1'b0;
      sc_result_q <= 1'b0;
    end else begin
      sc_active <= sc_valid;
      if (sc_valid && !sc_active) begin
        sc_result_q <= sc_match;
      end
    end
  end

  // Reservation state and its timeout counter. The branch order encodes the
  // priority: invalidate_all beats LR, and LR beats snoop, timeout and SC end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsv_valid <= 1'b0;
      rsv_addr  <= '0;
      cnt       <= '0;
    end else if (invalidate_all) begin
      rsv_valid <= 1'b0;
      cnt       <= '0;
    end else if (lr_valid) begin
      rsv_valid <= 1'b1;
      rsv_addr  <= lr_addr & GRAN_MASK;
      cnt       <= '0;
    end else if (clear_req) begin
      rsv_valid <= 1'b0;
      cnt       <= '0;
    end else if (rsv_valid && !sc_active) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_lr_sc_reservation.sv
// Bench for lr_sc_reservation: directed scenarios plus randomized traffic,
// compared against a reservation model written in plain integers.
module tb_lr_sc_reservation;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lr_valid = 1'b0;
  logic [31:0] lr_addr = '0;
  logic        sc_valid = 1'b0;
  logic [31:0] sc_addr = '0;
  logic        sc_success;
  logic        snoop_we = 1'b0;
  logic [31:0] snoop_addr = '0;
  logic        invalidate_all = 1'b0;
  logic        rsv_valid;
  logic [31:0] rsv_addr;

  int checks = 0;
  int errors = 0;

  // Reference model: one reservation, its granule number and its live age.
  bit          m_valid;
  int unsigned m_gran;
  int          m_age;
  bit          m_in_sc;
  bit          m_sc_res;

  lr_sc_reservation #(
    .XLEN(32), .GRANULE_LSB(3), .TIMEOUT_CYCLES(TO), .CNT_W(16)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .lr_valid(lr_valid), .lr_addr(lr_addr),
    .sc_valid(sc_valid), .sc_addr(sc_addr), .sc_success(sc_success),
    .snoop_we(snoop_we), .snoop_addr(snoop_addr),
    .invalidate_all(invalidate_all),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned gran(input logic [31:0] a);
    return a >> 3;
  endfunction

  function automatic bit m_holds(input logic [31:0] a);
    return m_valid && (gran(a) == m_gran);
  endfunction

  function automatic bit m_expect_sc();
    if (!sc_valid) return 1'b0;
    if (m_in_sc) return m_sc_res;
    return m_holds(sc_addr);
  endfunction

  task automatic m_reset();
    m_valid = 0; m_gran = 0; m_age = 0; m_in_sc = 0; m_sc_res = 0;
  endtask

  // Apply one clock edge of rules to the model, using the inputs of this cycle.
  task automatic m_edge();
    bit expired, sc_done, conflict;
    expired  = m_valid && (m_age == TO - 1);
    sc_done  = !sc_valid && m_in_sc;
    conflict = snoop_we && m_holds(snoop_addr);
    if (sc_valid && !m_in_sc) m_sc_res = m_holds(sc_addr);
    if (invalidate_all) begin
      m_valid = 0; m_age = 0;
    end else if (lr_valid) begin
      m_valid = 1; m_gran = gran(lr_addr); m_age = 0;
    end else if (conflict || expired || sc_done) begin
      m_valid = 0; m_age = 0;
    end else if (m_valid && !m_in_sc) begin
      m_age++;
    end
    m_in_sc = sc_valid;
  endtask

  // One cycle: compare outputs against the model, take the edge, drop pulses.
  task automatic cyc();
    #2;
    check("sc_success", {31'b0, sc_success}, {31'b0, m_expect_sc()});
    check("rsv_valid", {31'b0, rsv_valid}, {31'b0, m_valid});
    if (m_valid) check("rsv_addr", rsv_addr, m_gran << 3);
    @(posedge clk);
    m_edge();
    #1;
    lr_valid = 0; snoop_we = 0; invalidate_all = 0;
  endtask

  // Cycle with an additional fixed expectation on sc_success.
  task automatic cyc_sc(input string tag, input bit exp);
    #1;
    check(tag, {31'b0, sc_success}, {31'b0, exp});
    cyc();
  endtask

  task automatic do_lr(input logic [31:0] a);
    lr_valid = 1; lr_addr = a;
    cyc();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // SC window of len cycles with a fixed expected outcome, then the closing cycle.
  task automatic do_sc(input string tag, input logic [31:0] a, input int len, input bit exp);
    sc_valid = 1; sc_addr = a;
    for (int i = 0; i < len; i++) cyc_sc(tag, exp);
    sc_valid = 0;
    cyc_sc({tag, "_off"}, 1'b0);
    #1 check({tag, "_consumed"}, {31'b0, rsv_valid}, 32'd0);
  endtask

  task automatic apply_reset();
    reset_n = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  initial begin
    int win_left;
    bit gap;
    m_reset();
    apply_reset();
    #1;
    check("rst_rsv_valid", {31'b0, rsv_valid}, 32'd0);
    check("rst_rsv_addr", rsv_addr, 32'd0);
    check("rst_sc_success", {31'b0, sc_success}, 32'd0);

    // Matching SC held for three cycles, same granule with a different offset.
    do_lr(32'h8000_0010);
    #1 check("lr_addr_masked", rsv_addr, 32'h8000_0010);
    do_sc("sc_match", 32'h8000_0014, 3, 1'b1);

    // SC to the neighbouring granule fails but still consumes.
    do_lr(32'h8000_0010);
    do_sc("sc_other_gran", 32'h8000_0018, 2, 1'b0);

    // Snoop to the same granule kills the reservation, a neighbouring one does not.
    do_lr(32'h0000_1000);
    snoop_we = 1; snoop_addr = 32'h0000_1004; cyc();
    do_sc("snoop_same", 32'h0000_1000, 1, 1'b0);
    do_lr(32'h0000_1000);
    snoop_we = 1; snoop_addr = 32'h0000_1008; cyc();
    do_sc("snoop_other", 32'h0000_1000, 1, 1'b1);

    // Timeout boundary: 8 idle cycles expire, 7 do not.
    do_lr(32'h0000_2000);
    idle(TO);
    #1 check("timeout_expired", {31'b0, rsv_valid}, 32'd0);
    do_sc("sc_after_timeout", 32'h0000_2000, 1, 1'b0);
    do_lr(32'h0000_2000);
    idle(TO - 1);
    do_sc("sc_before_timeout", 32'h0000_2000, 1, 1'b1);

    // Outcome frozen across a snoop and a trap inside the window.
    do_lr(32'h0000_4000);
    sc_valid = 1; sc_addr = 32'h0000_4000;
    cyc_sc("frozen_open", 1'b1);
    snoop_we = 1; snoop_addr = 32'h0000_4004;
    cyc_sc("frozen_snoop", 1'b1);
    invalidate_all = 1;
    cyc_sc("frozen_inv", 1'b1);
    cyc_sc("frozen_tail", 1'b1);
    sc_valid = 0;
    cyc_sc("frozen_off", 1'b0);

    // LR loses to invalidate_all in the same cycle; LR beats a same-granule snoop.
    lr_valid = 1; lr_addr = 32'h0000_3000; invalidate_all = 1;
    cyc();
    #1 check("lr_vs_inv", {31'b0, rsv_valid}, 32'd0);
    lr_valid = 1; lr_addr = 32'h0000_3000; snoop_we = 1; snoop_addr = 32'h0000_3000;
    cyc();
    #1 check("lr_vs_snoop", {31'b0, rsv_valid}, 32'd1);

    // Reset in the middle of an SC window takes effect immediately.
    do_lr(32'h0000_3000);
    sc_valid = 1; sc_addr = 32'h0000_3000;
    cyc_sc("pre_reset_sc", 1'b1);
    #2 reset_n = 0;
    #1;
    check("reset_mid_sc", {31'b0, sc_success}, 32'd0);
    check("reset_mid_rsv", {31'b0, rsv_valid}, 32'd0);
    m_reset();
    @(posedge clk);
    #1 reset_n = 1;
    cyc_sc("post_reset_sc", 1'b0);
    sc_valid = 0;
    cyc();

    // Randomized traffic over a few neighbouring granules.
    win_left = 0;
    gap = 0;
    for (int n = 0; n < 3000; n++) begin
      if (win_left > 0) begin
        win_left--;
        if (win_left == 0) begin sc_valid = 0; gap = 1; end
      end else if (!gap && $urandom_range(0, 7) == 0) begin
        sc_valid = 1;
        sc_addr = 32'h100 + 32'($urandom_range(0, 3)) * 4;
        win_left = $urandom_range(1, 4);
      end else begin
        gap = 0;
      end
      if ($urandom_range(0, 9) == 0) begin
        lr_valid = 1; lr_addr = 32'h100 + 32'($urandom_range(0, 3)) * 4;
      end
      if ($urandom_range(0, 4) == 0) begin
        snoop_we = 1; snoop_addr = 32'h100 + 32'($urandom_range(0, 3)) * 4;
      end
      if ($urandom_range(0, 39) == 0) invalidate_all = 1;
      cyc();
    end
    sc_valid = 0;
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
